string_to_board: RTL and testbench
==================================

STRING_TO_BOARD -- requirements
Module: string_to_board

Interface
REQ-001 Parameter TILE_W, default 20, bits per tile value.
REQ-002 Parameter NUM_TILES, default 16, tiles per board (row-major, 4x4).
REQ-003 Parameter SCORE_W, default 21, bits of parsed score.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  begin a new parse; one-cycle pulse.
REQ-007 char_in  input  8  ASCII character.
REQ-008 char_valid  input  1  char_in holds a character.
REQ-009 char_ready  output  1  block accepts char_in this cycle.
REQ-010 board  output  NUM_TILES*TILE_W  parsed tiles; tile k = row*4+col at bits [k*TILE_W +: TILE_W].
REQ-011 score  output  SCORE_W  parsed score.
REQ-012 done  output  1  level; high when idle with a complete result or after reset.
REQ-013 error  output  1  level; high after an illegal character until next start.

Function
REQ-014 Transfer occurs only on a cycle with char_valid=1 and char_ready=1; other cycles leave all state unchanged.
REQ-015 States: IDLE, SKIP (between numbers), NUM (accumulating tile), SSKIP, SNUM (score), ERR.
REQ-016 char_ready=1 in SKIP, NUM, SSKIP, SNUM; 0 in IDLE and ERR.
REQ-017 start in any state: board<=0, score<=0, tile index<=0, accumulator<=0, done<=0, error<=0, next state SKIP; a char presented the same cycle is not consumed.
REQ-018 Separator set: space, '|', '-', CR, LF, ':', 'a'..'z'.
REQ-019 SKIP: separator stays SKIP; digit loads accumulator with digit value, to NUM; other char to ERR.
REQ-020 NUM: digit sets acc = acc*10 + digit, saturating at 2^TILE_W-1; separator writes acc to tile[index], clears acc, increments index, to SKIP; other char to ERR.
REQ-021 Commit of tile NUM_TILES-1 goes to SSKIP (score enabled) or IDLE with done=1 next cycle (score disabled).
REQ-022 SSKIP/SNUM: same rules as SKIP/NUM, accumulator saturating at 2^SCORE_W-1; separator in SNUM writes score, to IDLE, done=1 next cycle.
REQ-023 More than 7 digits in one number saturates, not an error.
REQ-024 ERR: done=0, error=1, board/score hold partial values until start.
REQ-025 Characters presented in IDLE or ERR are not consumed (char_ready=0) and ignored.
REQ-026 Latency: done rises the cycle after the terminating separator is accepted.

Reset
REQ-027 On rst: state IDLE, board=0, score=0, done=1, error=0, char_ready=0, accumulator and index 0.
REQ-028 rst mid-parse aborts immediately with the reset values above; no partial commit.

Configuration
REQ-029 Macro STB_SCORE_EN defined: score parsed per REQ-022 after the last tile.
REQ-030 STB_SCORE_EN undefined: SSKIP/SNUM absent, score tied to 0, done after last tile.

Structure
REQ-031 Package game2048_pkg holds TILE_W, NUM_TILES, SCORE_W, ASCII constants (space, pipe, dash, CR, LF, colon, '0', 'a', 'z') and the state enum.
REQ-032 One sub-module ascii_class: combinational, char_in -> is_digit, is_sep, digit value[3:0].

Verification
REQ-033 Reset then idle -> done=1, error=0, board=0, char_ready=0.
REQ-034 start, stream "|0002|0004|...|" grid holding 2,4,0,...,2048 at tile 15, then "score: 0000128\n" -> board tile0=2, tile1=4, tile15=2048, score=128, done=1 one cycle after LF.
REQ-035 Same stream with char_valid toggled every other cycle -> identical board/score; done timing tracks last accepted LF.
REQ-036 Tile "99999999 " (8 digits) -> tile0=1048575 saturated, error=0.
REQ-037 '#' after 3 tiles -> error=1, done=0, char_ready=0; tiles 0..2 retained; later start clears error and board.
REQ-038 rst asserted after 5 tiles -> next cycle board=0, done=1, state IDLE; build without STB_SCORE_EN -> done right after tile 15, score=0.

Source files
------------

// File: rtl/game2048_pkg.sv
// Shared constants and FSM state type for the 2048 board text parser.
package game2048_pkg;

  localparam int unsigned TILE_W    = 20;
  localparam int unsigned NUM_TILES = 16;
  localparam int unsigned SCORE_W   = 21;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_PIPE  = 8'h7C;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A_LO  = 8'h61;
  localparam logic [7:0] ASCII_Z_LO  = 8'h7A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_NUM,
    ST_SSKIP,
    ST_SNUM,
    ST_ERR
  } state_t;

endpackage

// File: rtl/ascii_class.sv
// Combinational character classifier: decimal digit, field separator, digit value.
module ascii_class
  import game2048_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       is_digit,
  output logic       is_sep,
  output logic [3:0] digit
);

  logic [7:0] offset;

  always_comb begin
    offset   = char_in - ASCII_ZERO;
    digit    = offset[3:0];
    is_digit = (char_in >= ASCII_ZERO) && (char_in <= (ASCII_ZERO + 8'd9));
    is_sep   = (char_in == ASCII_SPACE) || (char_in == ASCII_PIPE) ||
               (char_in == ASCII_DASH)  || (char_in == ASCII_CR)   ||
               (char_in == ASCII_LF)    || (char_in == ASCII_COLON) ||
               ((char_in >= ASCII_A_LO) && (char_in <= ASCII_Z_LO));
  end

endmodule

// File: rtl/string_to_board.sv
// Parses a streamed ASCII 2048 grid into row-major tiles with saturating decimal fields.
// Define STB_SCORE_EN to also parse a trailing score after the last tile.
module string_to_board #(
  parameter int unsigned TILE_W    = game2048_pkg::TILE_W,
  parameter int unsigned NUM_TILES = game2048_pkg::NUM_TILES,
  parameter int unsigned SCORE_W   = game2048_pkg::SCORE_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [7:0]                    char_in,
  input  logic                          char_valid,
  output logic                          char_ready,
  output logic [NUM_TILES*TILE_W-1:0]   board,
  output logic [SCORE_W-1:0]            score,
  output logic                          done,
  output logic                          error
);
  import game2048_pkg::*;

  localparam int unsigned ACC_W = (SCORE_W > TILE_W) ? SCORE_W : TILE_W;
  localparam int unsigned IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TILES - 1);
  localparam logic [ACC_W+3:0] TILE_MAX = {{(ACC_W+4-TILE_W){1'b0}}, {TILE_W{1'b1}}};
`ifdef STB_SCORE_EN
  localparam logic [ACC_W+3:0] SCORE_MAX = {{(ACC_W+4-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};
`endif

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [ACC_W+3:0]   acc_sum, sat_max;
  logic [IDX_W-1:0]   idx;
  logic               is_digit, is_sep;
  logic [3:0]         digit;
  logic               xfer, last_tile;

  ascii_class u_class (
    .char_in  (char_in),
    .is_digit (is_digit),
    .is_sep   (is_sep),
    .digit    (digit)
  );

  assign xfer      = char_valid & char_ready;
  assign last_tile = (idx == LAST_IDX);

  // acc*10 + digit, clamped to the limit of whichever field is being parsed
  always_comb begin
    acc_sum = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{ACC_W{1'b0}}, digit};
    sat_max = TILE_MAX;
`ifdef STB_SCORE_EN
    if (state == ST_SNUM) sat_max = SCORE_MAX;
`endif
    acc_next = (acc_sum > sat_max) ? sat_max[ACC_W-1:0] : acc_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_SKIP;
    end else if (xfer) begin
      unique case (state)
        ST_SKIP: begin
          if (is_digit)     state_nxt = ST_NUM;
          else if (!is_sep) state_nxt = ST_ERR;
        end
        ST_NUM: begin
          if (is_sep) begin
`ifdef STB_SCORE_EN
            state_nxt = last_tile ? ST_SSKIP : ST_SKIP;
`else
            state_nxt = last_tile ? ST_IDLE : ST_SKIP;
`endif
          end else if (!is_digit) begin
            state_nxt = ST_ERR;
          end
        end
`ifdef STB_SCORE_EN
        ST_SSKIP: begin
          if (is_digit)     state_nxt = ST_SNUM;
          else if (!is_sep) state_nxt = ST_ERR;
        end
        ST_SNUM: begin
          if (is_sep)         state_nxt = ST_IDLE;
          else if (!is_digit) state_nxt = ST_ERR;
        end
`endif
        default: state_nxt = state;
      endcase
    end
  end

  // IDLE is only reachable through reset or a completed parse, so it alone marks done
  always_comb begin
    char_ready = (state == ST_SKIP) || (state == ST_NUM) ||
                 (state == ST_SSKIP) || (state == ST_SNUM);
    done       = (state == ST_IDLE);
    error      = (state == ST_ERR);
  end

`ifdef STB_SCORE_EN
  logic [SCORE_W-1:0] score_q;
  assign score = score_q;
`else
  assign score = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board <= '0;
      acc   <= '0;
      idx   <= '0;
`ifdef STB_SCORE_EN
      score_q <= '0;
`endif
    end else if (start) begin
      board <= '0;
      acc   <= '0;
      idx   <= '0;
`ifdef STB_SCORE_EN
      score_q <= '0;
`endif
    end else if (xfer) begin
      unique case (state)
        ST_SKIP, ST_SSKIP: begin
          if (is_digit) acc <= {{(ACC_W-4){1'b0}}, digit};
        end
        ST_NUM: begin
          if (is_digit) begin
            acc <= acc_next;
          end else if (is_sep) begin
            for (int unsigned k = 0; k < NUM_TILES; k++) begin
              if (idx == IDX_W'(k)) board[k*TILE_W +: TILE_W] <= acc[TILE_W-1:0];
            end
            acc <= '0;
            idx <= idx + 1'b1;
          end
        end
`ifdef STB_SCORE_EN
        ST_SNUM: begin
          if (is_digit) begin
            acc <= acc_next;
          end else if (is_sep) begin
            score_q <= acc[SCORE_W-1:0];
            acc     <= '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_string_to_board.sv
// Randomized self-checking bench for string_to_board against a text-level parse model.
module tb_string_to_board;

  localparam int unsigned TILE_W    = 20;
  localparam int unsigned NUM_TILES = 16;
  localparam int unsigned SCORE_W   = 21;
  localparam longint unsigned TMAX  = (64'd1 << TILE_W) - 1;
  localparam longint unsigned SMAX  = (64'd1 << SCORE_W) - 1;
`ifdef STB_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic                        clk = 1'b0;
  logic                        rst, start, char_valid;
  logic [7:0]                  char_in;
  logic                        char_ready, done, error;
  logic [NUM_TILES*TILE_W-1:0] board;
  logic [SCORE_W-1:0]          score;

  int n_checks = 0;
  int n_errors = 0;

  longint unsigned m_board[NUM_TILES];
  longint unsigned m_score;
  int              m_end;
  bit              m_err;

  string fixed_s;

  string_to_board #(
    .TILE_W    (TILE_W),
    .NUM_TILES (NUM_TILES),
    .SCORE_W   (SCORE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .board      (board),
    .score      (score),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit tb_is_digit(input byte c);
    return (int'(c) >= 48) && (int'(c) <= 57);
  endfunction

  function automatic bit tb_is_sep(input byte c);
    string seps = " |-\r\n:";
    for (int j = 0; j < seps.len(); j++)
      if (c == seps[j]) return 1'b1;
    return (int'(c) >= 97) && (int'(c) <= 122);
  endfunction

  // Token-level reading of the text: numbers end at separators, anything else aborts.
  function automatic void model(input string s);
    longint unsigned val = 0;
    bit in_num = 0;
    bit in_score = 0;
    int t = 0;
    for (int k = 0; k < NUM_TILES; k++) m_board[k] = 0;
    m_score = 0;
    m_end   = -1;
    m_err   = 0;
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      if (tb_is_digit(c)) begin
        val = (in_num ? val * 10 : 0) + longint'(int'(c) - 48);
        if (val > (in_score ? SMAX : TMAX)) val = in_score ? SMAX : TMAX;
        in_num = 1;
      end else if (tb_is_sep(c)) begin
        if (in_num) begin
          in_num = 0;
          if (in_score) begin
            m_score = val;
            m_end = i;
            return;
          end
          m_board[t] = val;
          t++;
          if (t == NUM_TILES) begin
            if (SCORE_EN) in_score = 1;
            else begin
              m_end = i;
              return;
            end
          end
        end
      end else begin
        m_err = 1;
        m_end = i;
        return;
      end
    end
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; char_valid = 1'b1; char_in = "7";
    @(negedge clk);
    start = 1'b0; char_valid = 1'b0;
    check("start_done", done, 0);
    check("start_error", error, 0);
    check("start_ready", char_ready, 1);
    check("start_board_zero", 64'(board == '0), 1);
    check("start_score_zero", 64'(score), 0);
  endtask

  task automatic run_stream(input string s, input bit gaps);
    int  i = 0;
    int  budget = 0;
    bit  fin, v;
    model(s);
    while (budget < 3000) begin
      @(negedge clk);
      fin = (m_end >= 0) && (i > m_end);
      check("done_level", done, 64'(fin && !m_err));
      check("error_level", error, 64'(fin && m_err));
      check("ready_level", char_ready, 64'(!fin));
      if (fin || i >= s.len()) break;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      char_valid = v;
      char_in    = v ? s[i] : 8'($urandom);
      if (v && char_ready) i++;
      budget++;
    end
    char_valid = 1'b0;
    if (budget >= 3000) check("stream_timeout", 1, 0);
    if (fin) begin
      repeat (3) begin
        @(negedge clk);
        char_valid = 1'b1;
        char_in    = 8'($urandom_range(48, 57));
      end
      @(negedge clk);
      char_valid = 1'b0;
    end
  endtask

  task automatic check_result(input string tag);
    for (int k = 0; k < NUM_TILES; k++)
      check($sformatf("%s_tile%0d", tag, k), 64'(board[k*TILE_W +: TILE_W]), m_board[k]);
    check({tag, "_score"}, 64'(score), SCORE_EN ? m_score : 0);
    check({tag, "_done"}, done, 64'((m_end >= 0) && !m_err));
    check({tag, "_error"}, error, 64'(m_err));
  endtask

  function automatic string rand_sep();
    string seps = " |-\r\n:";
    byte c;
    if ($urandom_range(0, 2) == 0) c = byte'(97 + $urandom_range(0, 25));
    else                           c = seps[$urandom_range(0, 5)];
    return $sformatf("%c", c);
  endfunction

  function automatic string build_fixed();
    int unsigned vals[16] = '{2, 4, 0, 8, 16, 0, 32, 64, 0, 128, 256, 512, 1024, 0, 4, 2048};
    string s = "";
    for (int r = 0; r < 4; r++) begin
      s = {s, "|"};
      for (int c = 0; c < 4; c++) s = {s, $sformatf("%04d|", vals[r*4+c])};
      s = {s, "\n"};
    end
    return {s, "score: 0000128\n"};
  endfunction

  function automatic string build_random();
    string s = "|";
    longint unsigned v;
    for (int k = 0; k < NUM_TILES; k++) begin
      case ($urandom_range(0, 3))
        0:       v = 0;
        1:       v = longint'(1) << $urandom_range(1, 17);
        2:       v = $urandom_range(0, 1048575);
        default: v = $urandom_range(1000000, 99999999);
      endcase
      repeat ($urandom_range(0, 2)) s = {s, "0"};
      s = {s, $sformatf("%0d", v)};
      repeat ($urandom_range(1, 2)) s = {s, rand_sep()};
    end
    return {s, "score: ", $sformatf("%0d", $urandom_range(0, 99999999)), "\n"};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; char_valid = 1'b0; char_in = '0;
    repeat (2) @(negedge clk);
    check("rst_done", done, 1);
    check("rst_error", error, 0);
    check("rst_ready", char_ready, 0);
    check("rst_board", 64'(board == '0), 1);
    check("rst_score", 64'(score), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", done, 1);

    fixed_s = build_fixed();
    do_start(); run_stream(fixed_s, 1'b0); check_result("fixed");
    check("fixed_tile15", 64'(board[15*TILE_W +: TILE_W]), 2048);
    do_start(); run_stream(fixed_s, 1'b1); check_result("fixed_gap");

    do_start(); run_stream("|99999999 12345 |", 1'b0); check_result("sat");
    check("sat_tile0", 64'(board[TILE_W-1:0]), 1048575);

    do_start(); run_stream("|2|4|8|#|16|", 1'b0); check_result("illegal");
    do_start();

    do_start(); run_stream("|1|2|3", 1'b0);
    do_start(); run_stream(fixed_s, 1'b0); check_result("restart");

    do_start(); run_stream("|1|2|3|4|5|6", 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_board", 64'(board == '0), 1);
    check("midrst_done", done, 1);
    check("midrst_error", error, 0);
    check("midrst_ready", char_ready, 0);
    rst = 1'b0;

    for (int n = 0; n < 8; n++) begin
      string s;
      s = build_random();
      do_start();
      run_stream(s, n[0]);
      check_result($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
